mc_core_hs: RTL and testbench

//  Parametrised multicycle processor core: datapath, register file and control FSM in one block.

---
 rtl/mc_core_hs.sv | 236 +++++++++++++++++++++++
 tb/tb_mc_core_hs.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_core_hs.sv
// Multicycle core: datapath, 32-entry register file and control FSM, with handshake
// ports to external instruction and data memories of arbitrary latency.
module mc_core_hs #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [31:0]           instr,
  output logic [3:0]            state,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  halted,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  cycle_cnt,
  output logic [CNT_WIDTH-1:0]  retire_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [5:0] OP_ORI   = 6'h02;
  localparam logic [5:0] OP_LW    = 6'h03;
  localparam logic [5:0] OP_SW    = 6'h04;
  localparam logic [5:0] OP_BEQ   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h06;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;
  localparam logic [3:0] FN_XOR = 4'd4;
  localparam logic [3:0] FN_SLT = 4'd5;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_WB     = 4'd4,
    S_HALT   = 4'd5
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [31:0]           instr_reg;
  logic [DATA_WIDTH-1:0] alu_reg, a_reg, b_reg, mdr_reg;
  logic [CNT_WIDTH-1:0]  cycle_reg, retire_reg;
  logic [DATA_WIDTH-1:0] regs_reg [32];

  logic [5:0]            op;
  logic [4:0]            rs, rt, rd;
  logic [3:0]            fn;
  logic [15:0]           imm;
  logic [DATA_WIDTH-1:0] sext, zext, rs_val, rt_val, alu_res, wb_data;
  logic [ADDR_WIDTH-1:0] br_off;
  logic [4:0]            wb_addr;
  logic                  wb_en, op_legal, retire_c;

  assign op   = instr_reg[31:26];
  assign rs   = instr_reg[25:21];
  assign rt   = instr_reg[20:16];
  assign rd   = instr_reg[15:11];
  assign fn   = instr_reg[3:0];
  assign imm  = instr_reg[15:0];
  assign sext = DATA_WIDTH'($signed(imm));
  assign zext = DATA_WIDTH'(imm);
  assign br_off = ADDR_WIDTH'($signed(imm));

  assign rs_val = (rs == 5'd0) ? '0 : regs_reg[rs];
  assign rt_val = (rt == 5'd0) ? '0 : regs_reg[rt];

  assign wb_addr = (op == OP_RTYPE) ? rd : rt;
  assign wb_data = (op == OP_LW) ? mdr_reg : alu_reg;
  assign wb_en   = (state_reg == S_WB) && (wb_addr != 5'd0);

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_RTYPE: op_legal = (fn <= FN_SLT);
      OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  alu_res = a_reg + b_reg;
          FN_SUB:  alu_res = a_reg - b_reg;
          FN_AND:  alu_res = a_reg & b_reg;
          FN_OR:   alu_res = a_reg | b_reg;
          FN_XOR:  alu_res = a_reg ^ b_reg;
          FN_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
          default: alu_res = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_res = a_reg + sext;
      OP_ORI:                alu_res = a_reg | zext;
      OP_BEQ:                alu_res = a_reg - b_reg;
      default:               alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  // Requests and the illegal pulse are gated by reset so nothing escapes while it is held.
  always_comb begin
    state_next = state_reg;
    retire_c   = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    illegal    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        imem_req = reset;
        if (imem_req && imem_ack) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (!op_legal) begin
          illegal    = reset;
          state_next = S_FETCH;
        end else if (op == OP_HALT) begin
          state_next = S_HALT;
        end else if (op == OP_J) begin
          retire_c   = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op == OP_BEQ) begin
          retire_c   = 1'b1;
          state_next = S_FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = reset;
        if (dmem_req && dmem_ack) begin
          if (op == OP_SW) begin
            retire_c   = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        retire_c   = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg     <= RESET_PC;
      instr_reg  <= '0;
      alu_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      mdr_reg    <= '0;
      cycle_reg  <= '0;
      retire_reg <= '0;
    end else begin
      if (state_reg != S_HALT) cycle_reg <= cycle_reg + CNT_WIDTH'(1);
      if (retire_c) retire_reg <= retire_reg + CNT_WIDTH'(1);
      case (state_reg)
        S_FETCH: begin
          if (imem_req && imem_ack) begin
            instr_reg <= imem_rdata;
            pc_reg    <= pc_reg + ADDR_WIDTH'(1);
          end
        end
        S_DECODE: begin
          a_reg <= rs_val;
          b_reg <= rt_val;
          if (op == OP_J) pc_reg <= instr_reg[ADDR_WIDTH-1:0];
        end
        S_EXEC: begin
          alu_reg <= alu_res;
          // pc already points past the branch, so the offset is relative to pc+1.
          if (op == OP_BEQ && a_reg == b_reg) pc_reg <= pc_reg + br_off;
        end
        S_MEM: begin
          if (dmem_req && dmem_ack && op == OP_LW) mdr_reg <= dmem_rdata;
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < 32; gi++) begin : g_regfile
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) regs_reg[gi] <= '0;
      else if (wb_en && wb_addr == 5'(gi)) regs_reg[gi] <= wb_data;
    end
  end

  assign imem_addr  = pc_reg;
  assign dmem_we    = dmem_req && (op == OP_SW);
  assign dmem_addr  = alu_reg[ADDR_WIDTH-1:0];
  assign dmem_wdata = b_reg;
  assign pc         = pc_reg;
  assign instr      = instr_reg;
  assign state      = state_reg;
  assign alu_out    = alu_reg;
  assign halted     = (state_reg == S_HALT);
  assign cycle_cnt  = cycle_reg;
  assign retire_cnt = retire_reg;

endmodule

// File: tb/tb_mc_core_hs.sv
// Bench for mc_core_hs: handshake memory responders, an instruction-level reference
// interpreter, directed scenarios and randomly generated forward-flowing programs.
module tb_mc_core_hs;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int CW = 32;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req, imem_ack = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata = '0;
  logic [AW-1:0] pc;
  logic [31:0]   instr;
  logic [3:0]    state;
  logic [DW-1:0] alu_out;
  logic          halted, illegal;
  logic [CW-1:0] cycle_cnt, retire_cnt;

  always #5 clk = ~clk;

  mc_core_hs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(16'h0000), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .instr(instr), .state(state), .alu_out(alu_out),
    .halted(halted), .illegal(illegal), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  typedef struct { logic [15:0] addr; logic [31:0] data; } st_t;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int          iw_cfg = 0, dw_cfg = 0, i_cnt = 0, d_cnt = 0;
  bit          force_dack = 1'b0;
  st_t         dut_st[$], exp_st[$];
  int unsigned ret_cyc[$];
  logic [15:0] ret_pc[$];
  int          n_illegal = 0;
  logic [15:0] ill_pc = '0;
  logic [CW-1:0] last_ret = '0;
  int          exp_retire, exp_cycles, exp_illegal;
  logic [15:0] exp_pc;
  int          n_cmp = 0, n_bad = 0;

  // Memory responders: ack after a fixed number of wait cycles per transaction.
  always @(negedge clk) begin
    if (imem_req) begin
      if (i_cnt >= iw_cfg) begin imem_ack = 1'b1; imem_rdata = imem[imem_addr[7:0]]; i_cnt = 0; end
      else begin imem_ack = 1'b0; i_cnt++; end
    end else begin imem_ack = 1'b0; i_cnt = 0; end
    if (force_dack) dmem_ack = 1'b1;
    else if (dmem_req) begin
      if (d_cnt >= dw_cfg) begin
        dmem_ack = 1'b1; d_cnt = 0;
        if (dmem_we) begin
          dmem[dmem_addr[7:0]] = dmem_wdata;
          dut_st.push_back('{dmem_addr, dmem_wdata});
        end else dmem_rdata = dmem[dmem_addr[7:0]];
      end else begin dmem_ack = 1'b0; d_cnt++; end
    end else begin dmem_ack = 1'b0; d_cnt = 0; end
  end

  always @(negedge clk) begin
    if (retire_cnt !== last_ret) begin
      ret_cyc.push_back(cycle_cnt); ret_pc.push_back(pc); last_ret = retire_cnt;
    end
    if (illegal === 1'b1) begin n_illegal++; ill_pc = pc; end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 7'h00, 4'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rt, input int rs, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = HALT_W;
  endtask

  task automatic start_run(input int iw, input int dw);
    reset = 1'b0; force_dack = 1'b0; iw_cfg = iw; dw_cfg = dw;
    repeat (2) @(negedge clk);
    ret_cyc.delete(); ret_pc.delete(); dut_st.delete(); n_illegal = 0; last_ret = '0;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int k = 0;
    while (halted !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    check({tag, " halted"}, halted, 1);
  endtask

  // Instruction-level interpreter; cycles follow the per-class latencies plus waits.
  task automatic run_model(input int iw, input int dw);
    logic [31:0] mr [32];
    logic [31:0] mm [256];
    logic [15:0] p;
    logic [31:0] w, a, b, sx, zx, res, ea;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  fn;
    bit          done;
    for (int i = 0; i < 32; i++) mr[i] = '0;
    for (int i = 0; i < 256; i++) mm[i] = dmem[i];
    exp_st.delete(); exp_retire = 0; exp_cycles = 0; exp_illegal = 0; done = 1'b0; p = '0;
    for (int step = 0; step < 2000 && !done; step++) begin
      w = imem[p[7:0]];
      op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; fn = w[3:0];
      a = mr[rs]; b = mr[rt];
      sx = {{16{w[15]}}, w[15:0]}; zx = {16'h0, w[15:0]};
      p = p + 16'd1;
      exp_cycles += 2 + iw;
      case (op)
        6'h00: begin
          if (fn <= 4'd5) begin
            case (fn)
              4'd0: res = a + b;
              4'd1: res = a - b;
              4'd2: res = a & b;
              4'd3: res = a | b;
              4'd4: res = a ^ b;
              default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            endcase
            if (rd != 0) mr[rd] = res;
            exp_cycles += 2; exp_retire++;
          end else exp_illegal++;
        end
        6'h01: begin if (rt != 0) mr[rt] = a + sx; exp_cycles += 2; exp_retire++; end
        6'h02: begin if (rt != 0) mr[rt] = a | zx; exp_cycles += 2; exp_retire++; end
        6'h03: begin
          ea = a + sx;
          if (rt != 0) mr[rt] = mm[ea[7:0]];
          exp_cycles += 3 + dw; exp_retire++;
        end
        6'h04: begin
          ea = a + sx;
          mm[ea[7:0]] = b;
          exp_st.push_back('{ea[15:0], b});
          exp_cycles += 2 + dw; exp_retire++;
        end
        6'h05: begin if (a == b) p = p + w[15:0]; exp_cycles += 1; exp_retire++; end
        6'h06: begin p = w[15:0]; exp_retire++; end
        6'h3F: done = 1'b1;
        default: exp_illegal++;
      endcase
    end
    exp_pc = p;
  endtask

  task automatic compare_run(input string tag);
    check({tag, " retire"}, retire_cnt, exp_retire);
    check({tag, " cycles"}, cycle_cnt, exp_cycles);
    check({tag, " illegal"}, n_illegal, exp_illegal);
    check({tag, " pc"}, pc, exp_pc);
    check({tag, " nstores"}, dut_st.size(), exp_st.size());
    for (int i = 0; i < exp_st.size(); i++) begin
      if (i < dut_st.size()) begin
        check($sformatf("%s st%0d addr", tag, i), dut_st[i].addr, exp_st[i].addr);
        check($sformatf("%s st%0d data", tag, i), dut_st[i].data, exp_st[i].data);
      end
    end
  endtask

  task automatic gen_random(input int n);
    int kind, off, maxoff;
    clear_imem();
    for (int p = 0; p < n; p++) begin
      kind = $urandom_range(0, 99);
      if (kind < 40)      imem[p] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 5));
      else if (kind < 55) imem[p] = enc_i(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
      else if (kind < 65) imem[p] = enc_i(2, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
      else if (kind < 72) imem[p] = enc_i(3, $urandom_range(0, 7), 0, $urandom_range(0, 63));
      else if (kind < 80) imem[p] = enc_i(4, $urandom_range(0, 7), 0, $urandom_range(0, 63));
      else if (kind < 88) begin
        maxoff = (n - 1 - p > 3) ? 3 : n - 1 - p;
        off = $urandom_range(0, maxoff);
        imem[p] = enc_i(5, $urandom_range(0, 7), $urandom_range(0, 7), off);
      end
      else if (kind < 93) imem[p] = enc_i(6, 0, 0, $urandom_range(p + 1, n));
      else if (kind < 96) imem[p] = {6'($urandom_range(7, 62)), 26'($urandom)};
      else                imem[p] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(6, 15));
    end
    for (int r = 1; r < 8; r++) imem[n + r - 1] = enc_i(4, r, 0, 128 + r);
    imem[n + 7] = HALT_W;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k, iw, dw;
    clear_imem();
    for (int i = 0; i < 256; i++) dmem[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst pc", pc, 0);
    check("rst state", state, 0);
    check("rst instr", instr, 0);
    check("rst alu_out", alu_out, 0);
    check("rst cycle_cnt", cycle_cnt, 0);
    check("rst retire_cnt", retire_cnt, 0);
    check("rst imem_req", imem_req, 0);
    check("rst dmem_req", dmem_req, 0);
    check("rst illegal", illegal, 0);
    check("rst halted", halted, 0);

    // 1: ADDI/ADDI/ADD/HALT at zero wait
    clear_imem();
    imem[0] = enc_i(1, 1, 0, 5);
    imem[1] = enc_i(1, 2, 0, -3);
    imem[2] = enc_r(3, 1, 2, 0);
    imem[3] = HALT_W;
    start_run(0, 0);
    wait_halt("t1", 200);
    check("t1 retire_cnt", retire_cnt, 3);
    check("t1 cycle_cnt", cycle_cnt, 14);
    check("t1 alu_out r3", alu_out, 2);
    repeat (3) @(negedge clk);
    check("t1 cycle frozen", cycle_cnt, 14);
    check("t1 no imem_req in halt", imem_req, 0);

    // 2: SUB wraps to all ones, SLT signed
    clear_imem();
    imem[0] = enc_i(1, 1, 0, 1);
    imem[1] = enc_r(4, 0, 1, 1);
    imem[2] = enc_r(5, 4, 1, 5);
    imem[3] = enc_i(4, 4, 0, 0);
    imem[4] = enc_i(4, 5, 0, 1);
    imem[5] = HALT_W;
    start_run(1, 1);
    wait_halt("t2", 300);
    check("t2 nstores", dut_st.size(), 2);
    check("t2 r4", dut_st[0].data, 32'hFFFF_FFFF);
    check("t2 r5", dut_st[1].data, 1);

    // 3: SW then LW with 3 data wait cycles
    clear_imem();
    imem[0] = enc_i(1, 3, 0, 2);
    imem[1] = enc_i(4, 3, 0, 4);
    imem[2] = enc_i(3, 6, 0, 4);
    imem[3] = enc_i(4, 6, 0, 8);
    imem[4] = HALT_W;
    start_run(0, 3);
    wait_halt("t3", 300);
    check("t3 nstores", dut_st.size(), 2);
    check("t3 sw addr", dut_st[0].addr, 4);
    check("t3 sw data", dut_st[0].data, 2);
    check("t3 r6 via store", dut_st[1].data, 2);
    check("t3 sw cycles", ret_cyc[1] - ret_cyc[0], 7);
    check("t3 lw cycles", ret_cyc[2] - ret_cyc[1], 8);

    // 4: taken BEQ loop at pc=10, then not-taken BEQ
    clear_imem();
    imem[0]  = enc_i(1, 1, 0, 1);
    imem[1]  = enc_i(6, 0, 0, 10);
    imem[10] = enc_i(5, 1, 1, -1);
    start_run(0, 0);
    repeat (40) @(negedge clk);
    check("t4 j pc", ret_pc[1], 10);
    check("t4 j cycles", ret_cyc[1] - ret_cyc[0], 2);
    for (int i = 2; i < 6; i++) begin
      check($sformatf("t4 loop%0d pc", i), ret_pc[i], 10);
      check($sformatf("t4 loop%0d cycles", i), ret_cyc[i] - ret_cyc[i-1], 3);
    end
    check("t4 not halted", halted, 0);
    imem[10] = enc_i(5, 2, 1, -1);
    imem[11] = HALT_W;
    start_run(0, 0);
    wait_halt("t4b", 200);
    check("t4b fallthrough pc", ret_pc[2], 11);
    check("t4b retire", retire_cnt, 3);
    check("t4b final pc", pc, 12);

    // 5: illegal opcode and write to r0
    clear_imem();
    imem[0] = enc_i(1, 1, 0, 1);
    imem[1] = {6'h2A, 26'h0};
    imem[2] = enc_i(1, 0, 0, 7);
    imem[3] = enc_i(4, 0, 0, 20);
    imem[4] = HALT_W;
    start_run(0, 0);
    wait_halt("t5", 200);
    check("t5 illegal pulses", n_illegal, 1);
    check("t5 illegal pc", ill_pc, 2);
    check("t5 next fetch", ret_pc[1], 3);
    check("t5 retire", retire_cnt, 3);
    check("t5 cycles", cycle_cnt, 16);
    check("t5 r0 store data", dut_st[0].data, 0);

    // 6: reset in MEM with ack pending, stale ack across release
    clear_imem();
    imem[0] = enc_i(1, 1, 0, 3);
    imem[1] = enc_i(3, 2, 0, 5);
    imem[2] = enc_i(4, 2, 0, 6);
    imem[3] = HALT_W;
    dmem[5] = 32'h1234_5678;
    start_run(0, 10);
    k = 0;
    while (state !== 4'd3 && k < 50) begin @(negedge clk); k++; end
    check("t6 reached MEM", state, 3);
    reset = 1'b0;
    #1;
    check("t6 dmem_req in reset", dmem_req, 0);
    check("t6 imem_req in reset", imem_req, 0);
    check("t6 state in reset", state, 0);
    check("t6 pc in reset", pc, 0);
    check("t6 cycle in reset", cycle_cnt, 0);
    check("t6 retire in reset", retire_cnt, 0);
    force_dack = 1'b1; dmem_ack = 1'b1; iw_cfg = 2;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("t6 state after release", state, 0);
    check("t6 pc after release", pc, 0);
    @(negedge clk);
    check("t6 cycle one", cycle_cnt, 1);
    check("t6 still fetch", state, 0);
    check("t6 dmem_req low", dmem_req, 0);
    force_dack = 1'b0; dw_cfg = 0;
    dut_st.delete();
    wait_halt("t6", 300);
    check("t6 retire", retire_cnt, 3);
    check("t6 store data", dut_st[0].data, 32'h1234_5678);

    // Random programs against the interpreter
    for (int r = 0; r < 8; r++) begin
      gen_random(40);
      for (int i = 0; i < 256; i++) dmem[i] = $urandom;
      iw = $urandom_range(0, 2);
      dw = $urandom_range(0, 2);
      run_model(iw, dw);
      start_run(iw, dw);
      wait_halt($sformatf("rnd%0d", r), 4000);
      compare_run($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
